// File: rtl/fp_pkg.sv
// Shared floating-point datapath package.
//   SP_* / DP_*  : mantissa (with hidden bit) and biased exponent widths for
//                  single and double precision builds.
//   align_s1_t   : stage-1 record of the alignment pipe in its single-precision
//                  layout. The alignment pipe declares the same field order
//                  locally so the record scales with its MANT_W/EXP_W parameters.
package fp_pkg;

    localparam int SP_MANT_W = 24;
    localparam int SP_EXP_W  = 8;
    localparam int DP_MANT_W = 53;
    localparam int DP_EXP_W  = 11;

    typedef struct packed {
        logic [SP_EXP_W-1:0]  exp_max;
        logic [SP_MANT_W-1:0] mant_big;
        logic [SP_MANT_W-1:0] mant_small;
        logic [SP_EXP_W-1:0]  diff;
        logic                 swap;
    } align_s1_t;

endpackage

// File: rtl/align_shift_sticky.sv
// Combinational alignment shifter with sticky collection.
//   mant_small : mantissa of the smaller operand (hidden bit included)
//   diff       : exponent difference, any value up to 2^EXP_W-1
//   shifted    : {mant_small, 2'b00} >> diff, i.e. {mant, G, R}
//   sticky     : OR of every bit pushed below R
// Once diff reaches the full extended width, nothing survives the shift and
// every mantissa bit lands in sticky; this is forced explicitly so the result
// never depends on how a shifter handles oversized shift amounts.
module align_shift_sticky
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic [MANT_W-1:0] mant_small,
    input  logic [EXP_W-1:0]  diff,
    output logic [MANT_W+1:0] shifted,
    output logic              sticky
);

    localparam int W = MANT_W + 2;

    logic [W-1:0] ext;
    logic [W-1:0] lost_mask;
    logic [31:0]  diff_w;
    logic         sat;

    assign ext       = {mant_small, 2'b00};
    assign diff_w    = 32'(diff);
    assign sat       = (diff_w >= 32'(W));
    // Ones in the positions that fall off the bottom for this shift amount.
    assign lost_mask = ~({W{1'b1}} << diff);

    always_comb begin
        shifted = ext >> diff;
        sticky  = |(ext & lost_mask);
        if (sat) begin
            shifted = '0;
            sticky  = |mant_small;
        end
    end

endmodule

// File: rtl/align_shift_pipe.sv
// Two-stage mantissa alignment pipe for the FP adder.
//   clk, reset_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready   : input handshake
//   in_exp_a/b, in_mant_a/b : unpacked operands
//   out_valid / out_ready : output handshake
//   out_exp    : larger exponent
//   out_big    : unshifted mantissa of the larger operand
//   out_small  : aligned smaller mantissa {mant, G, R}
//   out_sticky : OR of the bits shifted out below R
//   out_swap   : 1 when B is the larger operand
// Stage 1 orders the operands and forms the exponent difference; stage 2
// performs the shift. Ready is purely combinational back through both stages
// (no skid buffer), so a full pipe accepts a new item in the same cycle the
// consumer drains one.
module align_shift_pipe
    import fp_pkg::*;
#(
    parameter int MANT_W = SP_MANT_W,
    parameter int EXP_W  = SP_EXP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp_a,
    input  logic [EXP_W-1:0]  in_exp_b,
    input  logic [MANT_W-1:0] in_mant_a,
    input  logic [MANT_W-1:0] in_mant_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_big,
    output logic [MANT_W+1:0] out_small,
    output logic              out_sticky,
    output logic              out_swap
);

    typedef struct packed {
        logic [EXP_W-1:0]  exp_max;
        logic [MANT_W-1:0] mant_big;
        logic [MANT_W-1:0] mant_small;
        logic [EXP_W-1:0]  diff;
        logic              swap;
    } s1_t;

    s1_t               s1_d;
    s1_t               s1_p1;
    logic              vld_p1;

    logic [EXP_W-1:0]  exp_p2;
    logic [MANT_W-1:0] big_p2;
    logic [MANT_W+1:0] small_p2;
    logic              sticky_p2;
    logic              swap_p2;
    logic              vld_p2;

    logic              adv1;
    logic              adv2;
    logic [MANT_W+1:0] shifted;
    logic              sticky;

    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;

    // ---- stage 1: operand ordering and exponent difference ----
    always_comb begin
        s1_d      = '0;
        // Equal operands keep A as the larger one, so swap stays 0.
        s1_d.swap = (in_exp_b > in_exp_a) ||
                    ((in_exp_a == in_exp_b) && (in_mant_b > in_mant_a));
        s1_d.diff = (in_exp_a >= in_exp_b) ? (in_exp_a - in_exp_b)
                                           : (in_exp_b - in_exp_a);
        if (s1_d.swap) begin
            s1_d.exp_max    = in_exp_b;
            s1_d.mant_big   = in_mant_b;
            s1_d.mant_small = in_mant_a;
        end else begin
            s1_d.exp_max    = in_exp_a;
            s1_d.mant_big   = in_mant_a;
            s1_d.mant_small = in_mant_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            s1_p1  <= '0;
        end else if (adv1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                s1_p1 <= s1_d;
            end
        end
    end

    // ---- stage 2: alignment shift and sticky ----
    align_shift_sticky #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_shift (
        .mant_small (s1_p1.mant_small),
        .diff       (s1_p1.diff),
        .shifted    (shifted),
        .sticky     (sticky)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2    <= 1'b0;
            exp_p2    <= '0;
            big_p2    <= '0;
            small_p2  <= '0;
            sticky_p2 <= 1'b0;
            swap_p2   <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                exp_p2    <= s1_p1.exp_max;
                big_p2    <= s1_p1.mant_big;
                small_p2  <= shifted;
                sticky_p2 <= sticky;
                swap_p2   <= s1_p1.swap;
            end
        end
    end

    // ---- outputs straight from stage 2 ----
    assign out_valid  = vld_p2;
    assign out_exp    = exp_p2;
    assign out_big    = big_p2;
    assign out_small  = small_p2;
    assign out_sticky = sticky_p2;
    assign out_swap   = swap_p2;

endmodule

// File: tb/tb_align_shift_pipe.sv
module tb_align_shift_pipe;

    logic        clk;
    logic        reset_n;

    // single-precision instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_exp_a, in_exp_b, out_exp;
    logic [23:0] in_mant_a, in_mant_b, out_big;
    logic [25:0] out_small;
    logic        out_sticky, out_swap;

    // double-precision instance
    logic        dp_in_valid, dp_in_ready, dp_out_valid, dp_out_ready;
    logic [10:0] dp_exp_a, dp_exp_b, dp_out_exp;
    logic [52:0] dp_mant_a, dp_mant_b, dp_out_big;
    logic [54:0] dp_out_small;
    logic        dp_out_sticky, dp_out_swap;

    int total;
    int bad;

    align_shift_pipe #(.MANT_W(24), .EXP_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
        .in_mant_a(in_mant_a), .in_mant_b(in_mant_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_big(out_big), .out_small(out_small),
        .out_sticky(out_sticky), .out_swap(out_swap)
    );

    align_shift_pipe #(.MANT_W(53), .EXP_W(11)) dut_dp (
        .clk(clk), .reset_n(reset_n),
        .in_valid(dp_in_valid), .in_ready(dp_in_ready),
        .in_exp_a(dp_exp_a), .in_exp_b(dp_exp_b),
        .in_mant_a(dp_mant_a), .in_mant_b(dp_mant_b),
        .out_valid(dp_out_valid), .out_ready(dp_out_ready),
        .out_exp(dp_out_exp), .out_big(dp_out_big), .out_small(dp_out_small),
        .out_sticky(dp_out_sticky), .out_swap(dp_out_swap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [23:0] ma;
        logic [23:0] mb;
        logic [7:0]  x_exp;
        logic [23:0] x_big;
        logic [25:0] x_small;
        logic        x_sticky;
        logic        x_swap;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] sp_out();
        return 128'({out_exp, out_big, out_small, out_sticky, out_swap});
    endfunction

    function automatic logic [127:0] sp_exp(input int i);
        return 128'({vecs[i].x_exp, vecs[i].x_big, vecs[i].x_small,
                     vecs[i].x_sticky, vecs[i].x_swap});
    endfunction

    task automatic drive_vec(input int i);
        in_exp_a  = vecs[i].ea;
        in_exp_b  = vecs[i].eb;
        in_mant_a = vecs[i].ma;
        in_mant_b = vecs[i].mb;
    endtask

    task automatic dp_case(input string name, input logic [10:0] ea, input logic [10:0] eb,
                           input logic [52:0] ma, input logic [52:0] mb,
                           input logic [127:0] req);
        @(negedge clk);
        dp_exp_a = ea; dp_exp_b = eb; dp_mant_a = ma; dp_mant_b = mb;
        dp_in_valid = 1'b1;
        @(negedge clk);
        dp_in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 128'(dp_out_valid), 128'(1));
        check(name, 128'({dp_out_exp, dp_out_big, dp_out_small, dp_out_sticky, dp_out_swap}), req);
    endtask

    int sent, recv, stall_left;
    logic seen, saw_full;

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        in_exp_a = '0; in_exp_b = '0; in_mant_a = '0; in_mant_b = '0;
        dp_in_valid = 1'b0; dp_out_ready = 1'b1;
        dp_exp_a = '0; dp_exp_b = '0; dp_mant_a = '0; dp_mant_b = '0;

        //             ea     eb     ma          mb          exp    big         small        st    sw
        vecs[0]  = '{8'h85, 8'h82, 24'h800000, 24'hC00001, 8'h85, 24'h800000, 26'h0600000, 1'b1, 1'b0};
        vecs[1]  = '{8'h10, 8'h40, 24'hFFFFFF, 24'h800000, 8'h40, 24'h800000, 26'h0000000, 1'b1, 1'b1};
        vecs[2]  = '{8'h10, 8'h40, 24'h000000, 24'h800000, 8'h40, 24'h800000, 26'h0000000, 1'b0, 1'b1};
        vecs[3]  = '{8'h7F, 8'h7F, 24'h800000, 24'h900000, 8'h7F, 24'h900000, 26'h2000000, 1'b0, 1'b1};
        vecs[4]  = '{8'h7F, 8'h7F, 24'hA00000, 24'hA00000, 8'h7F, 24'hA00000, 26'h2800000, 1'b0, 1'b0};
        vecs[5]  = '{8'h99, 8'h80, 24'h800000, 24'hFFFFFF, 8'h99, 24'h800000, 26'h0000001, 1'b1, 1'b0};
        vecs[6]  = '{8'h9A, 8'h80, 24'h800000, 24'h000001, 8'h9A, 24'h800000, 26'h0000000, 1'b1, 1'b0};
        vecs[7]  = '{8'h81, 8'h80, 24'h800000, 24'h000001, 8'h81, 24'h800000, 26'h0000002, 1'b0, 1'b0};
        vecs[8]  = '{8'h83, 8'h80, 24'h800000, 24'h000001, 8'h83, 24'h800000, 26'h0000000, 1'b1, 1'b0};
        vecs[9]  = '{8'hFF, 8'h00, 24'hFFFFFF, 24'h123456, 8'hFF, 24'hFFFFFF, 26'h0000000, 1'b1, 1'b0};
        vecs[10] = '{8'h20, 8'h20, 24'hC00000, 24'h800000, 8'h20, 24'hC00000, 26'h2000000, 1'b0, 1'b0};
        vecs[11] = '{8'h80, 8'h82, 24'h000003, 24'h800000, 8'h82, 24'h800000, 26'h0000003, 1'b0, 1'b1};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_data", sp_out(), 128'(0));
        check("rst_dp_valid", 128'(dp_out_valid), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // single items through the table, with latency check
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_vec(i);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_lat1", i), 128'(out_valid), 128'(0));
            @(negedge clk);
            check($sformatf("vec%0d_lat2", i), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d_data", i), sp_out(), sp_exp(i));
        end

        // back-to-back stream of 6 with a 3-cycle output stall
        @(negedge clk);
        sent = 0; recv = 0; stall_left = 0; seen = 1'b0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (sent < 6) begin
                drive_vec(sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (out_valid) begin
                if (out_ready) begin
                    check($sformatf("stream%0d", recv), sp_out(), sp_exp(recv));
                    recv++;
                end else begin
                    check($sformatf("hold%0d", recv), sp_out(), sp_exp(recv));
                end
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 128'(recv), 128'(6));
        check("in_ready_fell", 128'(saw_full), 128'(1));
        @(negedge clk);
        #1;
        check("stream_drained", 128'(out_valid), 128'(0));

        // reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        drive_vec(0);
        in_valid = 1'b1;
        @(negedge clk);
        drive_vec(1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_before_rst", 128'(out_valid), 128'(1));
        check("full_in_ready", 128'(in_ready), 128'(0));
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_data", sp_out(), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("no_stale%0d", k), 128'(out_valid), 128'(0));
        end

        // double-precision build
        dp_case("dp_diff54", 11'h436, 11'h400, 53'h10000000000000, 53'h1,
                128'({11'h436, 53'h10000000000000, 55'h0, 1'b1, 1'b0}));
        dp_case("dp_diff55", 11'h400, 11'h437, 53'h1, 53'h10000000000000,
                128'({11'h437, 53'h10000000000000, 55'h0, 1'b1, 1'b1}));
        dp_case("dp_diff52", 11'h434, 11'h400, 53'h1FFFFFFFFFFFFF, 53'h10000000000000,
                128'({11'h434, 53'h1FFFFFFFFFFFFF, 55'h4, 1'b0, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
